// File: rtl/alu_mdu.sv
// alu_mdu: handshaked execute-stage ALU with iterative RV32M multiply and optional divide.
// Define ALU_MDU_DIV_EN to build the divider (DIV/DIVU/REM/REMU); otherwise those ops return 0.
module alu_mdu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_PASSB  = 5'd10;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
`ifdef ALU_MDU_DIV_EN
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
`endif

    state_e state_q, state_d;

    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        op_q;
    logic [SHW-1:0]    count_q;
    logic              negMul_q;

    logic              accept, isMul, lastStep;
    logic              aSigned, bSigned, aNeg, bNeg;
    logic [XLEN-1:0]   absA, absB;
    logic [XLEN:0]     mulSum;
    logic [2*XLEN-1:0] mulNext, mulProd;
    logic [XLEN-1:0]   mulRes;

`ifdef ALU_MDU_DIV_EN
    logic              negQuo_q, negRem_q;
    logic              isDiv, divFast;
    logic [XLEN-1:0]   divFastRes, divQuo, divRem, divRes;
    logic [XLEN:0]     divShift, divDiff;
    logic [2*XLEN-1:0] divNext;
`endif

    function automatic logic [XLEN-1:0] aluCalc(input logic [4:0] f,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (f)
            OP_ADD:   aluCalc = a + b;
            OP_SUB:   aluCalc = a - b;
            OP_SLL:   aluCalc = a << sh;
            OP_SLT:   aluCalc = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:  aluCalc = {{(XLEN-1){1'b0}}, a < b};
            OP_XOR:   aluCalc = a ^ b;
            OP_SRL:   aluCalc = a >> sh;
            OP_SRA:   aluCalc = $signed(a) >>> sh;
            OP_OR:    aluCalc = a | b;
            OP_AND:   aluCalc = a & b;
            OP_PASSB: aluCalc = b;
            default:  aluCalc = '0;
        endcase
    endfunction

    // Request decode and conversion of operands to magnitudes per op signedness
    always_comb begin
        accept  = in_valid && in_ready;
        isMul   = (op[4:2] == 3'b100);
        aSigned = (op == OP_MULH) || (op == OP_MULHSU);
        bSigned = (op == OP_MULH);
`ifdef ALU_MDU_DIV_EN
        isDiv = (op[4:2] == 3'b101);
        if (op == OP_DIV || op == OP_REM) begin
            aSigned = 1'b1;
            bSigned = 1'b1;
        end
`endif
        aNeg = aSigned && src1[XLEN-1];
        bNeg = bSigned && src2[XLEN-1];
        absA = aNeg ? -src1 : src1;
        absB = bNeg ? -src2 : src2;
    end

`ifdef ALU_MDU_DIV_EN
    // Division by zero and signed overflow finish without iterating
    always_comb begin
        divFast    = 1'b0;
        divFastRes = '0;
        if (src2 == '0) begin
            divFast    = 1'b1;
            divFastRes = op[1] ? src1 : '1;
        end else if (aSigned && src1 == MOST_NEG && src2 == '1) begin
            divFast    = 1'b1;
            divFastRes = op[1] ? '0 : src1;
        end
    end
`endif

    // One iteration step of each datapath plus final sign fix-up and half select
    always_comb begin
        lastStep = (count_q == SHW'(XLEN - 1));
        mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mulNext  = {mulSum, acc_q[XLEN-1:1]};
        mulProd  = negMul_q ? -mulNext : mulNext;
        mulRes   = (op_q == OP_MUL) ? mulProd[XLEN-1:0] : mulProd[2*XLEN-1:XLEN];
`ifdef ALU_MDU_DIV_EN
        divShift = acc_q[2*XLEN-1:XLEN-1];
        divDiff  = divShift - {1'b0, opnd_q};
        if (divDiff[XLEN])
            divNext = {divShift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            divNext = {divDiff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        divQuo = negQuo_q ? -divNext[XLEN-1:0] : divNext[XLEN-1:0];
        divRem = negRem_q ? -divNext[2*XLEN-1:XLEN] : divNext[2*XLEN-1:XLEN];
        divRes = op_q[1] ? divRem : divQuo;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (isMul) state_d = S_MUL;
`ifdef ALU_MDU_DIV_EN
                    else if (isDiv && !divFast) state_d = S_DIV;
`endif
                    else state_d = S_DONE;
                end
            end
            S_MUL:   if (lastStep) state_d = S_DONE;
`ifdef ALU_MDU_DIV_EN
            S_DIV:   if (lastStep) state_d = S_DONE;
`endif
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_MUL);
`ifdef ALU_MDU_DIV_EN
        if (state_q == S_DIV) busy = 1'b1;
`endif
    end

    assign result = result_q;

    // Operands latched on acceptance; accumulator shared by multiplier and divider
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            op_q     <= '0;
            count_q  <= '0;
            negMul_q <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            negQuo_q <= 1'b0;
            negRem_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= op;
                        count_q <= '0;
                        if (isMul) begin
                            acc_q    <= {{XLEN{1'b0}}, absB};
                            opnd_q   <= absA;
                            negMul_q <= aNeg ^ bNeg;
                        end
`ifdef ALU_MDU_DIV_EN
                        else if (isDiv) begin
                            acc_q    <= {{XLEN{1'b0}}, absA};
                            opnd_q   <= absB;
                            negQuo_q <= aNeg ^ bNeg;
                            negRem_q <= aNeg;
                            if (divFast) result_q <= divFastRes;
                        end
`endif
                        else begin
                            result_q <= aluCalc(op, src1, src2);
                        end
                    end
                end
                S_MUL: begin
                    acc_q   <= mulNext;
                    count_q <= count_q + 1'b1;
                    if (lastStep) result_q <= mulRes;
                end
`ifdef ALU_MDU_DIV_EN
                S_DIV: begin
                    acc_q   <= divNext;
                    count_q <= count_q + 1'b1;
                    if (lastStep) result_q <= divRes;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (XLEN=32); expectations follow ALU_MDU_DIV_EN when defined.
module tb_alu_mdu;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic [31:0] expQ [$];
    int checks = 0;
    int passes = 0;

    alu_mdu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src1(src1), .src2(src2), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference for every op code
    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sp;
        longint unsigned ua, ub, up;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        model = '0;
        case (o)
            5'd0:  model = a + b;
            5'd1:  model = a - b;
            5'd2:  model = a << b[4:0];
            5'd3:  model = (ia < ib) ? 32'd1 : 32'd0;
            5'd4:  model = (a < b) ? 32'd1 : 32'd0;
            5'd5:  model = a ^ b;
            5'd6:  model = a >> b[4:0];
            5'd7:  model = $signed(a) >>> b[4:0];
            5'd8:  model = a | b;
            5'd9:  model = a & b;
            5'd10: model = b;
            5'd16: begin sp = sa * sb; model = sp[31:0]; end
            5'd17: begin sp = sa * sb; model = sp[63:32]; end
            5'd18: begin sp = sa * longint'(ub); model = sp[63:32]; end
            5'd19: begin up = ua * ub; model = up[63:32]; end
`ifdef ALU_MDU_DIV_EN
            5'd20: model = (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(ia / ib);
            5'd21: model = (b == 0) ? 32'hFFFFFFFF : a / b;
            5'd22: model = (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(ia % ib);
            5'd23: model = (b == 0) ? a : a % b;
`endif
            default: model = '0;
        endcase
    endfunction

    function automatic int expLat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        expLat = 1;
        if (o >= 5'd16 && o <= 5'd19) expLat = XLEN + 1;
`ifdef ALU_MDU_DIV_EN
        if (o >= 5'd20 && o <= 5'd23 && b != 0 &&
            !((o == 5'd20 || o == 5'd22) && a == 32'h80000000 && b == 32'hFFFFFFFF))
            expLat = XLEN + 1;
`endif
    endfunction

    // Drive one request, hold it until accepted, then scramble inputs
    task automatic applyStimulus(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp, input bit push);
        int guard;
        op = o; src1 = a; src2 = b; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 5'($urandom); src1 = $urandom; src2 = $urandom;
        if (push) expQ.push_back(exp);
    endtask

    // Wait (bounded) for a result; latency counts the accept edge as 1
    task automatic collectOutput(output logic [31:0] got, output int lat, output int busyCnt, output bit vld);
        lat = 1;
        busyCnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busyCnt++;
            @(posedge clk); #1;
            lat++;
        end
        vld = out_valid;
        got = result;
        if (vld && out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0)
            $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b busy=%b result=%h, need 1 0 0 00000000",
                     in_ready, out_valid, busy, result);
        else passes++;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
        else passes++;
    endtask

    task automatic test_single_cycle();
        vec_t vq [$];
        logic [31:0] got, e;
        int lat, bc;
        bit vld;
        vq.push_back('{5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1});
        vq.push_back('{5'd7,  32'h80000000, 32'h00000024, 32'hF8000000, 1});
        vq.push_back('{5'd1,  32'd3,        32'd5,        32'hFFFFFFFE, 1});
        vq.push_back('{5'd2,  32'h00000001, 32'h00000021, 32'h00000002, 1});
        vq.push_back('{5'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1});
        vq.push_back('{5'd4,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
        vq.push_back('{5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1});
        vq.push_back('{5'd6,  32'h80000000, 32'h00000004, 32'h08000000, 1});
        vq.push_back('{5'd8,  32'h12340000, 32'h00005678, 32'h12345678, 1});
        vq.push_back('{5'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1});
        vq.push_back('{5'd10, 32'hDEADBEEF, 32'h12345000, 32'h12345000, 1});
        vq.push_back('{5'd11, 32'h11111111, 32'h22222222, 32'h00000000, 1});
        vq.push_back('{5'd31, 32'h11111111, 32'h22222222, 32'h00000000, 1});
        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(vq[i].op, vq[i].a, vq[i].b, vq[i].exp, 1'b1);
            collectOutput(got, lat, bc, vld);
            e = expQ.pop_front();
            checks++;
            if (!vld || got !== e)
                $display("[TB] FAIL alu_op%0d: result=%h valid=%b, need %h", vq[i].op, got, vld, e);
            else passes++;
            checks++;
            if (lat != vq[i].lat || bc != 0)
                $display("[TB] FAIL alu_lat_op%0d: latency=%0d busy=%0d, need %0d and 0", vq[i].op, lat, bc, vq[i].lat);
            else passes++;
        end
    endtask

    task automatic test_multi_cycle();
        vec_t vq [$];
        logic [31:0] got, e;
        int lat, bc;
        bit vld;
        vq.push_back('{5'd17, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 33});
        vq.push_back('{5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        vq.push_back('{5'd16, 32'd6,        32'd7,        32'd42,       33});
        vq.push_back('{5'd18, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33});
`ifdef ALU_MDU_DIV_EN
        vq.push_back('{5'd20, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
        vq.push_back('{5'd22, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
        vq.push_back('{5'd21, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
        vq.push_back('{5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vq.push_back('{5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
        vq.push_back('{5'd23, 32'd5,        32'd0,        32'd5,        1});
        vq.push_back('{5'd23, 32'd100,      32'd7,        32'd2,        33});
`else
        vq.push_back('{5'd21, 32'd10,       32'd3,        32'd0,        1});
        vq.push_back('{5'd20, 32'hFFFFFFF9, 32'd2,        32'd0,        1});
`endif
        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(vq[i].op, vq[i].a, vq[i].b, vq[i].exp, 1'b1);
            collectOutput(got, lat, bc, vld);
            e = expQ.pop_front();
            checks++;
            if (!vld || got !== e)
                $display("[TB] FAIL mdu_op%0d: result=%h valid=%b, need %h", vq[i].op, got, vld, e);
            else passes++;
            checks++;
            if (lat != vq[i].lat || bc != ((vq[i].lat > 1) ? XLEN : 0))
                $display("[TB] FAIL mdu_lat_op%0d: latency=%0d busy=%0d, need %0d", vq[i].op, lat, bc, vq[i].lat);
            else passes++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got, e, held;
        int lat, bc;
        bit vld;
        out_ready = 1'b0;
        applyStimulus(5'd0, 32'd1, 32'd2, 32'd3, 1'b1);
        collectOutput(got, lat, bc, vld);
        e = expQ.pop_front();
        checks++;
        if (!vld || got !== e || lat != 1)
            $display("[TB] FAIL bp_first: result=%h valid=%b latency=%0d, need %h 1 1", got, vld, lat, e);
        else passes++;
        held = e;
        in_valid = 1'b1; op = 5'd1; src1 = 32'd10; src2 = 32'd4;
        expQ.push_back(32'd6);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== held || in_ready !== 1'b0)
                $display("[TB] FAIL bp_hold%0d: valid=%b result=%h in_ready=%b, need 1 %h 0", i, out_valid, result, in_ready, held);
            else passes++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("[TB] FAIL bp_release: valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
        else passes++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = expQ.pop_front();
        checks++;
        if (out_valid !== 1'b1 || result !== e)
            $display("[TB] FAIL bp_next: valid=%b result=%h, need 1 %h", out_valid, result, e);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] got, e;
        int lat, bc;
        bit vld, rose;
`ifdef ALU_MDU_DIV_EN
        applyStimulus(5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);
`else
        applyStimulus(5'd16, 32'd6, 32'd7, 32'd42, 1'b0);
`endif
        repeat (9) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b1)
            $display("[TB] FAIL midop_busy: busy=%b, need 1", busy);
        else passes++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0)
            $display("[TB] FAIL midop_reset: in_ready=%b valid=%b busy=%b result=%h, need 1 0 0 0", in_ready, out_valid, busy, result);
        else passes++;
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) rose = 1'b1;
        end
        checks++;
        if (rose)
            $display("[TB] FAIL midop_abandon: out_valid rose=%b, need 0", rose);
        else passes++;
        applyStimulus(5'd1, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b1);
        collectOutput(got, lat, bc, vld);
        e = expQ.pop_front();
        checks++;
        if (!vld || got !== e || lat != 1)
            $display("[TB] FAIL midop_sub: result=%h valid=%b latency=%0d, need %h 1 1", got, vld, lat, e);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, e, a, b;
        logic [4:0] o;
        int lat, bc, pick, el;
        bit vld;
        for (int i = 0; i < 30; i++) begin
            pick = $urandom_range(0, 19);
            o = (pick <= 10) ? 5'(pick) : (pick <= 18) ? 5'(pick + 5) : 5'd31;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 9);
                default: b = $urandom;
            endcase
            el = expLat(o, a, b);
            applyStimulus(o, a, b, model(o, a, b), 1'b1);
            collectOutput(got, lat, bc, vld);
            e = expQ.pop_front();
            checks++;
            if (!vld || got !== e || lat != el)
                $display("[TB] FAIL rand%0d_op%0d: a=%h b=%h result=%h latency=%0d, need %h %0d", i, o, a, b, got, lat, e, el);
            else passes++;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; src1 = '0; src2 = '0;
        test_reset();
        test_single_cycle();
        test_multi_cycle();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
